// File: rtl/rgb_sequencer_if.sv
// Pin bundle between the slide switches / LEDs and the RGB sequencer.
// The board side drives SW and observes the LEDs; the sequencer is the slave.
interface rgb_sequencer_if;
  logic [3:0] SW;
  logic [3:0] LED;
  logic       LED17_B;
  logic       LED17_G;
  logic       LED17_R;

  modport master (output SW, input LED, LED17_B, LED17_G, LED17_R);
  modport slave  (input SW, output LED, LED17_B, LED17_G, LED17_R);
endinterface

// File: rtl/rgb_sequencer.sv
// Rotates LED17 through the enabled red/green/blue channels with a fixed dwell,
// PWM-dimming the lit channel; status LEDs mirror the enable and selected colour.
module rgb_sequencer #(
  parameter int DWELL_TICKS = 100_000_000,
  parameter int PWM_BITS    = 8,
  parameter int DUTY        = 32
) (
  input logic            CLK100MHZ,
  input logic            reset,
  rgb_sequencer_if.slave io
);
  localparam int                 DW         = $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_CNT  = PWM_BITS'(DUTY);

  typedef enum logic [1:0] {IDLE, RED, GREEN, BLUE} state_t;

  logic [3:0]          sw_meta_reg;
  logic [3:0]          sw_s_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DW-1:0]       dwell_cnt_reg;
  state_t              state_reg;
  logic                led_en_reg;
  logic [2:0]          led_sel_reg;
  logic [2:0]          led17_reg;

  // Colour vectors are ordered {red, green, blue}, matching LED[3:1].
  logic [2:0] colour_en;
  logic [2:0] state_sel;
  logic [2:0] pwm_lit;
  logic       rot_on;
  logic       own_en;
  state_t     next_state;

  assign colour_en = sw_s_reg[3:1];
  assign rot_on    = sw_s_reg[0] && (colour_en != 3'b000);
  assign state_sel = {state_reg == RED, state_reg == GREEN, state_reg == BLUE};
  assign own_en    = |(state_sel & colour_en);

  // Search starts just after the current colour and checks the current one last.
  always_comb begin
    next_state = IDLE;
    case (state_reg)
      RED: begin
        if (colour_en[1])      next_state = GREEN;
        else if (colour_en[0]) next_state = BLUE;
        else if (colour_en[2]) next_state = RED;
      end
      GREEN: begin
        if (colour_en[0])      next_state = BLUE;
        else if (colour_en[2]) next_state = RED;
        else if (colour_en[1]) next_state = GREEN;
      end
      default: begin
        if (colour_en[2])      next_state = RED;
        else if (colour_en[1]) next_state = GREEN;
        else if (colour_en[0]) next_state = BLUE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pwm
      assign pwm_lit[gi] = state_sel[gi] && (pwm_cnt_reg < DUTY_CNT);
    end
  endgenerate

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sw_meta_reg   <= '0;
      sw_s_reg      <= '0;
      pwm_cnt_reg   <= '0;
      dwell_cnt_reg <= '0;
      state_reg     <= IDLE;
      led_en_reg    <= 1'b0;
      led_sel_reg   <= '0;
      led17_reg     <= '0;
    end else begin
      sw_meta_reg <= io.SW;
      sw_s_reg    <= sw_meta_reg;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      led_en_reg  <= sw_s_reg[0];
      led_sel_reg <= state_sel;
      led17_reg   <= pwm_lit;
      case (state_reg)
        IDLE: begin
          if (rot_on) begin
            state_reg     <= next_state;
            dwell_cnt_reg <= '0;
          end
        end
        default: begin
          // Enable changes take priority over dwell expiry.
          if (!rot_on) begin
            state_reg     <= IDLE;
            dwell_cnt_reg <= '0;
          end else if (!own_en || (dwell_cnt_reg == DWELL_LAST)) begin
            state_reg     <= next_state;
            dwell_cnt_reg <= '0;
          end else begin
            dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign io.LED     = {led_sel_reg, led_en_reg};
  assign io.LED17_R = led17_reg[2];
  assign io.LED17_G = led17_reg[1];
  assign io.LED17_B = led17_reg[0];

  a_pins_onehot0: assert property (@(posedge CLK100MHZ) disable iff (reset) $onehot0(led17_reg));
  a_sel_onehot0:  assert property (@(posedge CLK100MHZ) disable iff (reset) $onehot0(led_sel_reg));
endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed bench: dut_a (dwell 4, duty 2) is table-checked cycle by cycle; duty 7/0
// and dwell 1 variants share the switches and cover the duty and dwell extremes.
module tb_rgb_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;

  always #5 clk = ~clk;

  rgb_sequencer_if if_a ();
  rgb_sequencer_if if_b ();
  rgb_sequencer_if if_c ();
  rgb_sequencer_if if_d ();

  assign if_a.SW = sw;
  assign if_b.SW = sw;
  assign if_c.SW = sw;
  assign if_d.SW = sw;

  rgb_sequencer #(.DWELL_TICKS(4), .PWM_BITS(3), .DUTY(2)) dut_a (.CLK100MHZ(clk), .reset(rst), .io(if_a));
  rgb_sequencer #(.DWELL_TICKS(4), .PWM_BITS(3), .DUTY(7)) dut_b (.CLK100MHZ(clk), .reset(rst), .io(if_b));
  rgb_sequencer #(.DWELL_TICKS(4), .PWM_BITS(3), .DUTY(0)) dut_c (.CLK100MHZ(clk), .reset(rst), .io(if_c));
  rgb_sequencer #(.DWELL_TICKS(1), .PWM_BITS(3), .DUTY(7)) dut_d (.CLK100MHZ(clk), .reset(rst), .io(if_d));

  typedef struct {
    logic [3:0] sw;
    int         len;
    logic [3:0] led;
    logic [2:0] rgb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;

  // Restart after the mid-rotation reset: dut_a holds red, dut_d advances every cycle.
  logic [3:0] rs_a [0:6] = '{4'b0000, 4'b0000, 4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
  logic [3:0] rs_d [0:6] = '{4'b0000, 4'b0000, 4'b0001, 4'b1001, 4'b0101, 4'b0011, 4'b1001};

  function automatic void add(input logic [3:0] s, input int l, input logic [3:0] led, input logic [2:0] rgb);
    vec_t v;
    v.sw = s; v.len = l; v.led = led; v.rgb = rgb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, n, got, exp);
    end
  endtask

  function automatic logic [3:0] pins(input logic r, input logic g, input logic b);
    return {1'b0, r, g, b};
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", n);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_b;
    // all colours: red, green, blue, red, 4 cycles each
    add(4'b1111, 2, 4'b0000, 3'b000);
    add(4'b1111, 1, 4'b0001, 3'b000);
    add(4'b1111, 4, 4'b1001, 3'b000);
    add(4'b1111, 1, 4'b0101, 3'b000);
    add(4'b1111, 2, 4'b0101, 3'b010);
    add(4'b1111, 1, 4'b0101, 3'b000);
    add(4'b1111, 4, 4'b0011, 3'b000);
    add(4'b1111, 1, 4'b1001, 3'b000);
    add(4'b1111, 2, 4'b1001, 3'b100);
    add(4'b1111, 1, 4'b1001, 3'b000);
    // green off: green cut short, then blue/red alternate
    add(4'b1011, 3, 4'b0101, 3'b000);
    add(4'b1011, 2, 4'b0011, 3'b000);
    add(4'b1011, 2, 4'b0011, 3'b001);
    add(4'b1011, 4, 4'b1001, 3'b000);
    add(4'b1011, 2, 4'b0011, 3'b000);
    add(4'b1011, 2, 4'b0011, 3'b001);
    add(4'b1011, 4, 4'b1001, 3'b000);
    // blue only: held across dwell boundaries
    add(4'b0011, 2, 4'b0011, 3'b000);
    add(4'b0011, 2, 4'b0011, 3'b001);
    add(4'b0011, 6, 4'b0011, 3'b000);
    add(4'b0011, 2, 4'b0011, 3'b001);
    // rotation resumes, then master enable drops as green dwell expires
    add(4'b1111, 4, 4'b0011, 3'b000);
    add(4'b1111, 2, 4'b1001, 3'b000);
    add(4'b1111, 2, 4'b1001, 3'b100);
    add(4'b1111, 1, 4'b0101, 3'b000);
    add(4'b1110, 2, 4'b0101, 3'b000);
    add(4'b1110, 1, 4'b0100, 3'b000);
    add(4'b1110, 3, 4'b0000, 3'b000);
    add(4'b1111, 2, 4'b0000, 3'b000);
    add(4'b1111, 1, 4'b0001, 3'b000);
    add(4'b1111, 4, 4'b1001, 3'b000);
    add(4'b1111, 1, 4'b0101, 3'b010);
    // green enable drop seen on the dwell-expiry cycle
    add(4'b1011, 1, 4'b0101, 3'b010);
    add(4'b1011, 2, 4'b0101, 3'b000);
    add(4'b1011, 4, 4'b0011, 3'b000);
    add(4'b1011, 2, 4'b1001, 3'b100);
    add(4'b1011, 2, 4'b1001, 3'b000);
    add(4'b1011, 1, 4'b0011, 3'b000);

    rst = 1'b1;
    sw  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_led", if_a.LED, 4'b0000);
    check("reset_a_rgb", pins(if_a.LED17_R, if_a.LED17_G, if_a.LED17_B), 4'b0000);
    rst = 1'b0;

    foreach (vecs[r]) begin
      sw = vecs[r].sw;
      $display("vec %0d sw=%b cycles=%0d led=%b rgb=%b", r, vecs[r].sw, vecs[r].len, vecs[r].led, vecs[r].rgb);
      for (int k = 0; k < vecs[r].len; k++) begin
        @(posedge clk);
        #1;
        n++;
        // duty 7 of 8: lit colour is dark only when the sampled pwm count was 7
        exp_b = (n % 8 != 0) ? vecs[r].led[3:1] : 3'b000;
        check("a_led", if_a.LED, vecs[r].led);
        check("a_rgb", pins(if_a.LED17_R, if_a.LED17_G, if_a.LED17_B), {1'b0, vecs[r].rgb});
        check("b_led", if_b.LED, vecs[r].led);
        check("b_rgb", pins(if_b.LED17_R, if_b.LED17_G, if_b.LED17_B), {1'b0, exp_b});
        check("c_led", if_c.LED, vecs[r].led);
        check("c_rgb", pins(if_c.LED17_R, if_c.LED17_G, if_c.LED17_B), 4'b0000);
      end
    end

    // mid-blue reset: outputs must clear before any clock edge
    #2 rst = 1'b1;
    #1;
    $display("async reset asserted mid-blue at cycle %0d", n);
    check("async_a_led", if_a.LED, 4'b0000);
    check("async_b_led", if_b.LED, 4'b0000);
    check("async_b_rgb", pins(if_b.LED17_R, if_b.LED17_G, if_b.LED17_B), 4'b0000);
    check("async_d_led", if_d.LED, 4'b0000);
    sw = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      n++;
      $display("restart cycle %0d a_led=%b d_led=%b", n, if_a.LED, if_d.LED);
      check("rs_a_led", if_a.LED, rs_a[k]);
      check("rs_d_led", if_d.LED, rs_d[k]);
      check("rs_d_rgb", pins(if_d.LED17_R, if_d.LED17_G, if_d.LED17_B), {1'b0, rs_d[k][3:1]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_sequencer.md
Name: rgb_sequencer

Overview:
Sequencer for the board RGB LED (LED17) and the four status LEDs. It sequences the LED17 red/green/blue channels, lighting one colour at a time with a programmable dwell. Each lit channel is PWM-dimmed to a fixed duty. SW[0] is the master enable and SW[3:1] select which colours take part in the rotation. The block sits at top level between the slide switches and the LED pins.

Parameters:
DWELL_TICKS, 100_000_000, clock cycles each colour stays selected (1 s at 100 MHz); minimum 1.
PWM_BITS, 8, width of the free-running PWM counter; PWM period is 2^PWM_BITS cycles.
DUTY, 32, on-count per PWM period (PWM_BITS wide); 0 means always off.

Ports:
CLK100MHZ  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-high reset.
SW  input  4  SW[0] is master enable; SW[1]/SW[2]/SW[3] enable blue/green/red in the rotation. Asynchronous to the clock.
LED  output  4  LED[0] is the synchronised enable; LED[1]/LED[2]/LED[3] are one-hot "blue/green/red selected" flags.
LED17_B  output  1  blue channel, PWM.
LED17_G  output  1  green channel, PWM.
LED17_R  output  1  red channel, PWM.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, dwell counter 0, PWM counter 0, synchroniser flops 0.
- Input sync: SW passes through a 2-flop synchroniser and is used only as sw_s.
- PWM counter: free-running, increments every cycle and wraps 2^PWM_BITS-1 -> 0. It is not affected by the FSM.
- FSM states and ordering:
  - States: IDLE, RED, GREEN, BLUE.
  - Rotation order is RED -> GREEN -> BLUE -> RED, and only enabled colours are visited.
  - "Next enabled" means the first enabled colour after the current state in rotation order, wrapping around. The current colour itself is checked last.
- FSM transitions:
  - IDLE: stays in IDLE while sw_s[0]=0 or sw_s[3:1]=0. Otherwise it moves to the first enabled colour in the order R, G, B and clears the dwell counter.
  - Colour state, sw_s[0]=0 or no colours enabled: goes to IDLE on the next edge and clears the dwell counter.
  - Colour state, its own enable drops: moves to the next enabled colour on the next edge and clears the dwell counter.
  - Colour state, otherwise: the dwell counter increments. When it equals DWELL_TICKS-1, the FSM moves to the next enabled colour and the counter clears to 0.
  - If the current colour is the only one enabled, the FSM stays in it and the counter restarts.
- Dwell counter: width is $clog2(DWELL_TICKS+1). It never exceeds DWELL_TICKS-1.
- Outputs (all registered):
  - LED[0] = sw_s[0].
  - LED[3] = (state==RED), LED[2] = (state==GREEN), LED[1] = (state==BLUE).
  - LED17_R = (state==RED) && (pwm_cnt < DUTY); G and B are formed the same way.
  - In IDLE, all LED17 outputs are 0.
- Latency:
  - SW edge sampled at clock k: sync output valid at k+1, FSM state updated at k+2, pins updated at k+3.
  - A state change appears on the LED pins 1 cycle after the state register changes.
- Boundary conditions:
  - DUTY=0: LED17 outputs stay 0 while LED[3:1] still track the state.
  - DUTY=2^PWM_BITS-1: output is low exactly 1 cycle per PWM period.
  - DWELL_TICKS=1: the colour advances every cycle.
  - Simultaneous enable drop and dwell expiry: the drop wins (IDLE, or next enabled if only the channel enable dropped). The dwell counter is cleared.
  - Reset mid-rotation: immediate return to reset values. After release, the FSM restarts from IDLE and red has first priority again.
- Only one of LED17_R/G/B may be high in any cycle, and LED[3:1] is one-hot or all-zero. Both are checked by assertions.

Test Plan:
1. Parameters DWELL_TICKS=4, PWM_BITS=3, DUTY=2; SW=4'b1111 after reset -> LED[3] rises 4 cycles after the SW edge. Then red, green, blue, red, each selected for exactly 4 cycles. Each lit channel is high 2 of every 8 cycles, while pwm_cnt is 0 or 1.
2. SW=4'b1011 (green off) -> rotation is red, blue, red. LED[2] and LED17_G stay 0 throughout.
3. SW=4'b0011 (blue only) -> the FSM stays in BLUE indefinitely. LED[1]=1 and LED17_B pulses 2/8 with no gaps at dwell boundaries.
4. Rotation running, clear SW[0] -> 3 cycles later all LED17 pins and LED[3:0] are 0. Setting SW[0] again restarts at red.
5. During GREEN, drop SW[2] on the cycle the dwell counter reaches 3 -> the FSM enters BLUE with the dwell counter at 0. Blue then holds for a full 4 cycles.
6. Assert reset mid-BLUE with DUTY=7 -> all outputs go to 0 asynchronously, before the next clock edge. After release with SW=4'b1111, the FSM starts again at RED.
